usb_token_tx: RTL and testbench
===============================

Name: usb_token_tx

Overview:
- Token-packet assembler that sits directly upstream of crc5.
- On a start request it latches PID, address and endpoint, drives the 11 address/endpoint bits into the crc5 engine and captures the 5 CRC bits the engine streams back.
- Emits the complete serial token (SYNC, PID, ADDR, ENDP, CRC5) one bit per accepted cycle to the downstream bit-stuff/NRZI stage, then flags EOP.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC field, sent LSB-first.
- SYNC_LEN, 8, number of SYNC bits sent (1..8).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request token transmit; sampled only in IDLE
- pid  input  4  token PID (pid_n generated internally)
- addr  input  7  device address
- endp  input  4  endpoint number
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the EOP is accepted
- crc5_start  output  1  to crc5: one-cycle start pulse
- crc5_s_in  output  1  to crc5 s_in: serial data bit
- crc5_ready  input  1  from crc5: crc5_out valid this cycle
- crc5_out  input  1  from crc5: CRC bit stream
- crc5_done  input  1  from crc5: engine parked, awaiting ack
- crc5_rec  output  1  to crc5: CRC received acknowledge
- bit_out  output  1  serial token bit
- bit_valid  output  1  bit_out valid
- bit_stall  input  1  downstream stall; bit accepted when bit_valid && !bit_stall
- eop  output  1  end-of-packet request, held until accepted (eop && !bit_stall)

Behaviour:
- Reset (rst=1 at a clk edge): both FSMs go to IDLE. busy, done, crc5_start, crc5_s_in, crc5_rec, bit_out, bit_valid and eop are all 0. The CRC capture register and its valid flag are cleared. Reset mid-packet aborts with no done pulse; the crc5 engine shares the same reset source at top level.
- start is accepted only in TX IDLE. Accept latches pid/addr/endp, raises busy next cycle, and launches both FSMs the same cycle. start while busy is ignored.
- CRC FSM: C_IDLE -> C_START -> C_FEED -> C_CAPT -> C_ACK -> C_IDLE.
  - C_START: crc5_start=1 for exactly one cycle.
  - C_FEED: 11 consecutive cycles, crc5_s_in = {endp,addr} LSB-first (addr[0] first, endp[3] last). Never stalls.
  - C_CAPT: each cycle crc5_ready=1, shift crc5_out into a 5-bit capture register in arrival order. The 5th capture sets crc_valid.
  - C_ACK: once crc_valid && crc5_done, crc5_rec=1 for one cycle, then C_IDLE.
- TX FSM: IDLE -> SYNC (SYNC_LEN bits) -> PID (pid[0..3], then ~pid[0..3]) -> TOKEN (addr[0..6], endp[0..3]) -> WAIT_CRC -> CRC (5 bits, arrival order) -> EOP -> IDLE.
  - Bit counter advances only on accepted bits.
  - bit_valid=1 in SYNC/PID/TOKEN/CRC. bit_valid=0 in WAIT_CRC, IDLE and EOP.
  - WAIT_CRC exits the same cycle crc_valid is seen (zero-latency pass-through when CRC is already valid).
  - EOP: eop=1 until !bit_stall, then done=1 for one cycle, busy=0, return to IDLE.
- Latency: with bit_stall=0, the first SYNC bit appears the cycle after start acceptance. 32 bits total for SYNC_LEN=8. done is asserted 33 cycles after accept.
- bit_stall held indefinitely: TX freezes. The CRC FSM still completes and acks, since the engine cannot be stalled.

Optional Feature:
- USB_TOKEN_SOF_EN
  - Defined: adds input sof (1) and frame (11). When sof=1 at accept, the 11 CRC/TOKEN bits are frame[0..10] and pid is forced to the SOF PID.
  - Undefined: ports absent; tokens always carry addr/endp.

Decomposition:
- Package usb_pkg:
  - token PID constants: OUT 4'b0001, IN 4'b1001, SOF 4'b0101, SETUP 4'b1101.
  - field lengths: PID 8, TOKEN 11, CRC5 5.
  - enum typedefs for the TX and CRC states.
- Sub-module usb_token_crc_ctl: the CRC FSM plus capture register, exposing crc_valid/crc_bits. Field serialisation reuses piso_register.

Test Plan:
- IN, addr=0, endp=0, bit_stall=0 -> bytes after SYNC are 0x69,0x00,0x10 LSB-first (CRC5=5'b00010); done 33 cycles after start.
- SETUP, addr=0, endp=0 -> 0x2D,0x00,0x10; crc5_rec pulses exactly once; busy low after done.
- OUT, addr=7'h3A, endp=4'hA, random bit_stall 50% -> bit sequence identical to the unstalled run and to the software CRC5 model; no bit dropped or duplicated.
- bit_stall=1 held 40 cycles starting at the first PID bit -> CRC captured and acked during the stall; stream resumes at pid[0]; eop held until stall drops.
- rst pulsed mid-TOKEN, then new start IN addr=5 -> no done for the aborted packet; the new packet is correct from SYNC bit 0.
- start re-asserted every cycle while busy -> exactly one packet emitted per accepted start.

Source files
------------

// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB token transmitter slice.
//   - Token PID codes (4-bit PID, the check nibble is generated in the TX path)
//   - Field lengths in bits for the PID, token and CRC5 fields
//   - State enums for the TX serialiser FSM and the CRC5 control FSM
// No ports (package only).
// ---------------------------------------------------------------------------
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  localparam int PID_LEN   = 8;
  localparam int TOKEN_LEN = 11;
  localparam int CRC5_LEN  = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_PID,
    TX_TOKEN,
    TX_WAIT_CRC,
    TX_CRC,
    TX_EOP
  } txState_t;

  typedef enum logic [2:0] {
    C_IDLE,
    C_START,
    C_FEED,
    C_CAPT,
    C_ACK
  } crcState_t;

endpackage

// File: rtl/piso_register.sv
// ---------------------------------------------------------------------------
// piso_register
// Parallel-in / serial-out shift register, LSB first.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (clears the register)
//   i_load   load i_data (has priority over i_shift)
//   i_data   parallel word to serialise
//   i_shift  shift one position towards bit 0
//   o_serial current serial bit (register bit 0)
// ---------------------------------------------------------------------------
module piso_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  output logic             o_serial
);

  logic [WIDTH-1:0] r_data;

  // Load wins over shift so a restart always begins from a clean word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {1'b0, r_data[WIDTH-1:1]};
    end
  end

  assign o_serial = r_data[0];

endmodule

// File: rtl/usb_token_crc_ctl.sv
// ---------------------------------------------------------------------------
// usb_token_crc_ctl
// Drives the external crc5 engine for one token: start pulse, 11 serial
// field bits LSB first, captures the 5 returned CRC bits in arrival order
// and acknowledges the parked engine.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   i_launch      restart the sequence (token accepted this cycle)
//   i_field       11-bit field to feed ({endp,addr} or frame)
//   o_crc5Start   one-cycle start pulse to the engine
//   o_crc5SIn     serial data bit to the engine
//   i_crc5Ready   engine CRC bit valid this cycle
//   i_crc5Out     engine CRC bit
//   i_crc5Done    engine parked, waiting for acknowledge
//   o_crc5Rec     one-cycle acknowledge to the engine
//   o_crcValid    all 5 CRC bits captured
//   o_crcBits     captured CRC, bit 0 = first bit that arrived
// ---------------------------------------------------------------------------
module usb_token_crc_ctl
  import usb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_launch,
  input  logic [TOKEN_LEN-1:0] i_field,
  output logic                 o_crc5Start,
  output logic                 o_crc5SIn,
  input  logic                 i_crc5Ready,
  input  logic                 i_crc5Out,
  input  logic                 i_crc5Done,
  output logic                 o_crc5Rec,
  output logic                 o_crcValid,
  output logic [CRC5_LEN-1:0]  o_crcBits
);

  localparam logic [3:0] FEED_LAST = 4'(TOKEN_LEN - 1);
  localparam logic [3:0] CAPT_LAST = 4'(CRC5_LEN - 1);

  crcState_t           r_state;
  crcState_t           w_stateNext;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cntNext;
  logic                w_shift;
  logic                w_capture;
  logic                w_serial;
  logic                r_crcValid;
  logic [CRC5_LEN-1:0] r_crcBits;

  piso_register #(.WIDTH(TOKEN_LEN)) u_fieldPiso (
    .clk      (clk),
    .rst      (rst),
    .i_load   (i_launch),
    .i_data   (i_field),
    .i_shift  (w_shift),
    .o_serial (w_serial)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // The engine cannot be stalled, so feed and capture advance every cycle
  // regardless of what the TX side is doing. A launch restarts from any state.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_shift     = 1'b0;
    w_capture   = 1'b0;
    o_crc5Start = 1'b0;
    o_crc5SIn   = 1'b0;
    o_crc5Rec   = 1'b0;
    case (r_state)
      C_IDLE: ;
      C_START: begin
        o_crc5Start = 1'b1;
        w_stateNext = C_FEED;
        w_cntNext   = '0;
      end
      C_FEED: begin
        o_crc5SIn = w_serial;
        w_shift   = 1'b1;
        if (r_cnt == FEED_LAST) begin
          w_stateNext = C_CAPT;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 4'd1;
        end
      end
      C_CAPT: begin
        if (i_crc5Ready) begin
          w_capture = 1'b1;
          if (r_cnt == CAPT_LAST) begin
            w_stateNext = C_ACK;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + 4'd1;
          end
        end
      end
      C_ACK: begin
        if (r_crcValid && i_crc5Done) begin
          o_crc5Rec   = 1'b1;
          w_stateNext = C_IDLE;
        end
      end
      default: w_stateNext = C_IDLE;
    endcase
    if (i_launch) begin
      w_stateNext = C_START;
      w_cntNext   = '0;
    end
  end

  // Bits shift in from the top so after five captures bit 0 holds the
  // first arrival, which is also the first bit the TX side sends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crcBits  <= '0;
      r_crcValid <= 1'b0;
    end else if (i_launch) begin
      r_crcBits  <= '0;
      r_crcValid <= 1'b0;
    end else if (w_capture) begin
      r_crcBits <= {i_crc5Out, r_crcBits[CRC5_LEN-1:1]};
      if (r_cnt == CAPT_LAST) begin
        r_crcValid <= 1'b1;
      end
    end
  end

  assign o_crcValid = r_crcValid;
  assign o_crcBits  = r_crcBits;

endmodule

// File: rtl/usb_token_tx.sv
// ---------------------------------------------------------------------------
// usb_token_tx
// USB token packet assembler. Latches PID/address/endpoint on start, runs
// the crc5 engine through usb_token_crc_ctl and serialises
// SYNC, PID, ~PID, ADDR, ENDP, CRC5 one bit per accepted cycle, then EOP.
// Optional feature macro: USB_TOKEN_SOF_EN adds sof/frame inputs; with
// sof=1 at accept the token field is frame[10:0] and the PID is SOF.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           transmit request, only honoured while idle
//   pid, addr, endp token PID, device address, endpoint
//   sof, frame      (USB_TOKEN_SOF_EN only) SOF select and frame number
//   busy            packet in progress
//   done            one-cycle pulse when the EOP is accepted
//   crc5_*          handshake with the external crc5 engine
//   bit_out         serial token bit, bit_valid qualifies it
//   bit_stall       downstream stall; bit taken when bit_valid && !bit_stall
//   eop             end-of-packet request, held until !bit_stall
// ---------------------------------------------------------------------------
module usb_token_tx
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         SYNC_LEN     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  pid,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
`ifdef USB_TOKEN_SOF_EN
  input  logic        sof,
  input  logic [10:0] frame,
`endif
  output logic        busy,
  output logic        done,
  output logic        crc5_start,
  output logic        crc5_s_in,
  input  logic        crc5_ready,
  input  logic        crc5_out,
  input  logic        crc5_done,
  output logic        crc5_rec,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_stall,
  output logic        eop
);

  // A shortened SYNC keeps the tail of the pattern so the field still ends
  // on the pattern's final (MSB) bit.
  localparam logic [2:0] SYNC_FIRST = 3'(8 - SYNC_LEN);
  localparam logic [3:0] SYNC_LAST  = 4'(SYNC_LEN - 1);
  localparam logic [3:0] PID_LAST   = 4'(PID_LEN - 1);
  localparam logic [3:0] TOKEN_LAST = 4'(TOKEN_LEN - 1);
  localparam logic [3:0] CRC_LAST   = 4'(CRC5_LEN - 1);

  txState_t             r_state;
  txState_t             w_stateNext;
  logic [3:0]           r_bitCnt;
  logic [3:0]           w_cntNext;
  logic [3:0]           r_pid;
  logic [TOKEN_LEN-1:0] r_token;
  logic                 w_accept;
  logic [3:0]           w_pidSel;
  logic [TOKEN_LEN-1:0] w_field;
  logic [2:0]           w_syncIdx;
  logic                 w_crcValid;
  logic [CRC5_LEN-1:0]  w_crcBits;

`ifdef USB_TOKEN_SOF_EN
  assign w_pidSel = sof ? PID_SOF : pid;
  assign w_field  = sof ? frame : {endp, addr};
`else
  assign w_pidSel = pid;
  assign w_field  = {endp, addr};
`endif

  assign w_accept  = (r_state == TX_IDLE) && start;
  assign w_syncIdx = r_bitCnt[2:0] + SYNC_FIRST;
  assign busy      = (r_state != TX_IDLE);

  usb_token_crc_ctl u_crcCtl (
    .clk         (clk),
    .rst         (rst),
    .i_launch    (w_accept),
    .i_field     (w_field),
    .o_crc5Start (crc5_start),
    .o_crc5SIn   (crc5_s_in),
    .i_crc5Ready (crc5_ready),
    .i_crc5Out   (crc5_out),
    .i_crc5Done  (crc5_done),
    .o_crc5Rec   (crc5_rec),
    .o_crcValid  (w_crcValid),
    .o_crcBits   (w_crcBits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= TX_IDLE;
      r_bitCnt <= '0;
      r_pid    <= '0;
      r_token  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_cntNext;
      if (w_accept) begin
        r_pid   <= w_pidSel;
        r_token <= w_field;
      end
    end
  end

  // The bit counter only moves on accepted bits, so a stall simply holds the
  // current bit on bit_out. The last TOKEN bit jumps straight to CRC when the
  // CRC is already captured, so WAIT_CRC costs no cycle in the common case.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_bitCnt;
    bit_out     = 1'b0;
    bit_valid   = 1'b0;
    eop         = 1'b0;
    done        = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (start) begin
          w_stateNext = TX_SYNC;
          w_cntNext   = '0;
        end
      end
      TX_SYNC: begin
        bit_valid = 1'b1;
        bit_out   = SYNC_PATTERN[w_syncIdx];
        if (!bit_stall) begin
          if (r_bitCnt == SYNC_LAST) begin
            w_stateNext = TX_PID;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_bitCnt + 4'd1;
          end
        end
      end
      TX_PID: begin
        bit_valid = 1'b1;
        bit_out   = r_bitCnt[2] ? ~r_pid[r_bitCnt[1:0]] : r_pid[r_bitCnt[1:0]];
        if (!bit_stall) begin
          if (r_bitCnt == PID_LAST) begin
            w_stateNext = TX_TOKEN;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_bitCnt + 4'd1;
          end
        end
      end
      TX_TOKEN: begin
        bit_valid = 1'b1;
        bit_out   = r_token[r_bitCnt];
        if (!bit_stall) begin
          if (r_bitCnt == TOKEN_LAST) begin
            w_stateNext = w_crcValid ? TX_CRC : TX_WAIT_CRC;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_bitCnt + 4'd1;
          end
        end
      end
      TX_WAIT_CRC: begin
        if (w_crcValid) begin
          w_stateNext = TX_CRC;
          w_cntNext   = '0;
        end
      end
      TX_CRC: begin
        bit_valid = 1'b1;
        bit_out   = w_crcBits[r_bitCnt[2:0]];
        if (!bit_stall) begin
          if (r_bitCnt == CRC_LAST) begin
            w_stateNext = TX_EOP;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_bitCnt + 4'd1;
          end
        end
      end
      TX_EOP: begin
        eop = 1'b1;
        if (!bit_stall) begin
          done        = 1'b1;
          w_stateNext = TX_IDLE;
        end
      end
      default: w_stateNext = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_token_tx.sv
// ---------------------------------------------------------------------------
// tb_usb_token_tx
// Self-checking bench for usb_token_tx with a behavioural crc5 engine and a
// reference model that builds the expected 32-bit token from field values.
// ---------------------------------------------------------------------------
module tb_usb_token_tx;
   import usb_pkg::*;

   logic clk = 1'b0;
   logic rst, start, bit_stall;
   logic [3:0] pid, endp;
   logic [6:0] addr;
   logic crc5_ready, crc5_out, crc5_done;
   logic busy, done, crc5_start, crc5_s_in, crc5_rec, bit_out, bit_valid, eop;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   usb_token_tx dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pid        (pid),
      .addr       (addr),
      .endp       (endp),
`ifdef USB_TOKEN_SOF_EN
      .sof        (1'b0),
      .frame      (11'd0),
`endif
      .busy       (busy),
      .done       (done),
      .crc5_start (crc5_start),
      .crc5_s_in  (crc5_s_in),
      .crc5_ready (crc5_ready),
      .crc5_out   (crc5_out),
      .crc5_done  (crc5_done),
      .crc5_rec   (crc5_rec),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .bit_stall  (bit_stall),
      .eop        (eop)
   );

   // USB CRC5 over 11 bits sent LSB first; result returned in wire order
   // (bit 0 = first CRC bit on the bus), i.e. the inverted remainder MSB first.
   function automatic logic [4:0] usbCrc5(input logic [10:0] d);
      logic [4:0] c;
      logic [4:0] r;
      c = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
         else             c = {c[3:0], 1'b0};
      end
      for (int i = 0; i < 5; i++) r[i] = ~c[4 - i];
      return r;
   endfunction

   // Complete token in wire order: bit i is the i-th bit on the bus.
   function automatic logic [31:0] expectedStream(input logic [3:0] p, input logic [6:0] a,
                                                  input logic [3:0] e);
      return {usbCrc5({e, a}), e, a, ~p, p, 8'h80};
   endfunction

   // Behavioural crc5 engine: start, take 11 bits, stream 5 bits with ready,
   // then park with done until acknowledged.
   int eState, eCnt;
   logic [10:0] eBits;
   logic [4:0]  eSend;
   always @(posedge clk) begin
      if (rst) begin
         eState = 0;
         eCnt   = 0;
         crc5_ready <= 1'b0;
         crc5_out   <= 1'b0;
         crc5_done  <= 1'b0;
      end else if (crc5_start) begin
         eState = 1;
         eCnt   = 0;
         crc5_ready <= 1'b0;
         crc5_done  <= 1'b0;
      end else begin
         case (eState)
            1: begin
               eBits[eCnt] = crc5_s_in;
               if (eCnt == 10) begin
                  eSend = usbCrc5(eBits);
                  crc5_ready <= 1'b1;
                  crc5_out   <= eSend[0];
                  eCnt   = 1;
                  eState = 2;
               end else begin
                  eCnt++;
               end
            end
            2: begin
               if (eCnt == 5) begin
                  crc5_ready <= 1'b0;
                  crc5_out   <= 1'b0;
                  crc5_done  <= 1'b1;
                  eState = 3;
               end else begin
                  crc5_out <= eSend[eCnt];
                  eCnt++;
               end
            end
            3: begin
               if (crc5_rec) begin
                  crc5_done <= 1'b0;
                  eState = 0;
               end
            end
            default: ;
         endcase
      end
   end

   // Sends one token and records what the DUT did, cycle 1 being the cycle
   // after the accepting edge. stallMode: 0 none, 1 random 50%, 2 held for
   // cycles 9..48 (from the first PID bit for 40 cycles).
   task automatic runPacket(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                            input int stallMode, input bit holdStart,
                            output logic [31:0] gotVec, output int nBits, output int doneCyc,
                            output int startPulses, output int recCount, output int recInStall,
                            output int eopDrops, output logic busyAfter, output bit timedOut);
      int cyc;
      bit prevEopStall;
      gotVec = '0; nBits = 0; doneCyc = -1; startPulses = 0; recCount = 0;
      recInStall = 0; eopDrops = 0; timedOut = 0; prevEopStall = 0; cyc = 0;
      @(negedge clk);
      pid = p; addr = a; endp = e; start = 1'b1; bit_stall = 1'b0;
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      forever begin
         cyc++;
         case (stallMode)
            1:       bit_stall = 1'($urandom_range(0, 1));
            2:       bit_stall = (cyc >= 9 && cyc <= 48);
            default: bit_stall = 1'b0;
         endcase
         #1;
         if (crc5_start) startPulses++;
         if (crc5_rec) begin
            recCount++;
            if (bit_stall) recInStall++;
         end
         if (bit_valid && !bit_stall) begin
            if (nBits < 32) gotVec[nBits] = bit_out;
            nBits++;
         end
         if (prevEopStall && !eop) eopDrops++;
         prevEopStall = eop && bit_stall;
         if (done) begin
            doneCyc = cyc;
            start = 1'b0;
            break;
         end
         if (cyc >= 400) begin
            timedOut = 1;
            start = 1'b0;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bit_stall = 1'b0;
      #1;
      busyAfter = busy;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      string names [8] = '{"busy", "done", "crc5_start", "crc5_s_in", "crc5_rec",
                           "bit_out", "bit_valid", "eop"};
      rst = 1'b1; start = 1'b0; bit_stall = 1'b0; pid = '0; addr = '0; endp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      obs = {busy, done, crc5_start, crc5_s_in, crc5_rec, bit_out, bit_valid, eop};
      for (int i = 0; i < 8; i++) begin
         nChecks++;
         if (obs[7 - i] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_%s got %b expected 0", names[i], obs[7 - i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_in_zero();
      logic [31:0] got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      runPacket(PID_IN, 7'd0, 4'd0, 0, 0, got, nb, dc, sp, rc, ris, ed, ba, to);
      nChecks++; if (to !== 1'b0) begin nFails++; $display("[TB] FAIL in_timeout got %0b expected 0", to); end
      nChecks++; if (nb !== 32) begin nFails++; $display("[TB] FAIL in_bitcount got %0d expected 32", nb); end
      nChecks++; if (got[15:8] !== 8'h69) begin nFails++; $display("[TB] FAIL in_pidbyte got %h expected 69", got[15:8]); end
      nChecks++; if (got[23:16] !== 8'h00) begin nFails++; $display("[TB] FAIL in_addrbyte got %h expected 00", got[23:16]); end
      nChecks++; if (got[31:24] !== 8'h10) begin nFails++; $display("[TB] FAIL in_crcbyte got %h expected 10", got[31:24]); end
      nChecks++; if (got !== expectedStream(PID_IN, 7'd0, 4'd0)) begin
         nFails++; $display("[TB] FAIL in_stream got %h expected %h", got, expectedStream(PID_IN, 7'd0, 4'd0)); end
      nChecks++; if (dc !== 33) begin nFails++; $display("[TB] FAIL in_done_latency got %0d expected 33", dc); end
      nChecks++; if (sp !== 1) begin nFails++; $display("[TB] FAIL in_crc_start_pulses got %0d expected 1", sp); end
   endtask

   task automatic test_setup_zero();
      logic [31:0] got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      runPacket(PID_SETUP, 7'd0, 4'd0, 0, 0, got, nb, dc, sp, rc, ris, ed, ba, to);
      nChecks++; if (to !== 1'b0) begin nFails++; $display("[TB] FAIL setup_timeout got %0b expected 0", to); end
      nChecks++; if (got[15:8] !== 8'h2D) begin nFails++; $display("[TB] FAIL setup_pidbyte got %h expected 2d", got[15:8]); end
      nChecks++; if (got[31:24] !== 8'h10) begin nFails++; $display("[TB] FAIL setup_crcbyte got %h expected 10", got[31:24]); end
      nChecks++; if (rc !== 1) begin nFails++; $display("[TB] FAIL setup_rec_pulses got %0d expected 1", rc); end
      nChecks++; if (ba !== 1'b0) begin nFails++; $display("[TB] FAIL setup_busy_after_done got %b expected 0", ba); end
   endtask

   task automatic test_random_stall();
      logic [31:0] refVec, got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      runPacket(PID_OUT, 7'h3A, 4'hA, 0, 0, refVec, nb, dc, sp, rc, ris, ed, ba, to);
      runPacket(PID_OUT, 7'h3A, 4'hA, 1, 0, got, nb, dc, sp, rc, ris, ed, ba, to);
      nChecks++; if (to !== 1'b0) begin nFails++; $display("[TB] FAIL stall_timeout got %0b expected 0", to); end
      nChecks++; if (nb !== 32) begin nFails++; $display("[TB] FAIL stall_bitcount got %0d expected 32", nb); end
      nChecks++; if (got !== refVec) begin nFails++; $display("[TB] FAIL stall_vs_unstalled got %h expected %h", got, refVec); end
      nChecks++; if (got !== expectedStream(PID_OUT, 7'h3A, 4'hA)) begin
         nFails++; $display("[TB] FAIL stall_stream got %h expected %h", got, expectedStream(PID_OUT, 7'h3A, 4'hA)); end
      nChecks++; if (ed !== 0) begin nFails++; $display("[TB] FAIL stall_eop_dropped got %0d expected 0", ed); end
      nChecks++; if (rc !== 1) begin nFails++; $display("[TB] FAIL stall_rec_pulses got %0d expected 1", rc); end
   endtask

   task automatic test_stall_hold();
      logic [31:0] got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      logic [6:0] a; logic [3:0] e;
      a = 7'($urandom); e = 4'($urandom);
      runPacket(PID_IN, a, e, 2, 0, got, nb, dc, sp, rc, ris, ed, ba, to);
      nChecks++; if (ris !== 1) begin nFails++; $display("[TB] FAIL hold_rec_during_stall got %0d expected 1", ris); end
      nChecks++; if (got !== expectedStream(PID_IN, a, e)) begin
         nFails++; $display("[TB] FAIL hold_stream got %h expected %h", got, expectedStream(PID_IN, a, e)); end
      nChecks++; if (dc !== 73) begin nFails++; $display("[TB] FAIL hold_done_latency got %0d expected 73", dc); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      int doneSeen;
      doneSeen = 0;
      @(negedge clk);
      pid = PID_IN; addr = 7'd3; endp = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1; if (done) doneSeen++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1; if (done) doneSeen++;
         @(negedge clk);
      end
      #1;
      nChecks++; if (doneSeen !== 0) begin nFails++; $display("[TB] FAIL abort_done_seen got %0d expected 0", doneSeen); end
      nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
      runPacket(PID_IN, 7'd5, 4'd0, 0, 0, got, nb, dc, sp, rc, ris, ed, ba, to);
      nChecks++; if (got !== expectedStream(PID_IN, 7'd5, 4'd0)) begin
         nFails++; $display("[TB] FAIL abort_next_stream got %h expected %h", got, expectedStream(PID_IN, 7'd5, 4'd0)); end
      nChecks++; if (dc !== 33) begin nFails++; $display("[TB] FAIL abort_next_done got %0d expected 33", dc); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      logic [6:0] a; logic [3:0] e;
      for (int k = 0; k < 2; k++) begin
         a = 7'($urandom); e = 4'($urandom);
         runPacket(PID_OUT, a, e, 0, 1, got, nb, dc, sp, rc, ris, ed, ba, to);
         nChecks++; if (nb !== 32) begin nFails++; $display("[TB] FAIL b2b_bitcount got %0d expected 32", nb); end
         nChecks++; if (sp !== 1) begin nFails++; $display("[TB] FAIL b2b_crc_starts got %0d expected 1", sp); end
         nChecks++; if (got !== expectedStream(PID_OUT, a, e)) begin
            nFails++; $display("[TB] FAIL b2b_stream got %h expected %h", got, expectedStream(PID_OUT, a, e)); end
         nChecks++; if (ba !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_busy_after got %b expected 0", ba); end
      end
   endtask

   task automatic test_random();
      logic [31:0] got; int nb, dc, sp, rc, ris, ed; logic ba; bit to;
      logic [3:0] pids [4] = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP};
      logic [3:0] p, e; logic [6:0] a; int mode;
      for (int k = 0; k < 6; k++) begin
         p = pids[$urandom_range(0, 3)];
         a = 7'($urandom); e = 4'($urandom);
         mode = int'($urandom_range(0, 1));
         runPacket(p, a, e, mode, 0, got, nb, dc, sp, rc, ris, ed, ba, to);
         nChecks++; if (to !== 1'b0) begin nFails++; $display("[TB] FAIL rand_timeout got %0b expected 0", to); end
         nChecks++; if (got !== expectedStream(p, a, e) || nb !== 32) begin
            nFails++; $display("[TB] FAIL rand_stream got %h/%0d bits expected %h/32", got, nb, expectedStream(p, a, e)); end
      end
   endtask

   initial begin
      test_reset();
      test_in_zero();
      test_setup_zero();
      test_random_stall();
      test_stall_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
